// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and defaults for the fetch-side PC redirect controller.
`timescale 1ns/1ps
package pc_redirect_ctrl_pkg;

    localparam int DEF_PC_W = 16;
    localparam logic [DEF_PC_W-1:0] DEF_RESET_PC = 16'h0000;

    // Fetch control states; HALT and ERR are only left through reset.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_target.sv
// Branch/jump target computation: displacement (pc_add2 + disp) or
// register (rs + imm) target, modulo 2^PC_W, plus the misalign flag.
// Kept standalone so the EX-stage branch compare can reuse it.
`timescale 1ns/1ps
module pc_target_calc #(
    parameter int PC_W = 16
) (
    input  logic            jump_b_sel,
    input  logic [PC_W-1:0] pc_add2,
    input  logic [PC_W-1:0] disp,
    input  logic [PC_W-1:0] rs,
    input  logic [PC_W-1:0] imm,
    output logic [PC_W-1:0] tgt,
    output logic            misalign
);

    // Select the target source; carries out of the sum are dropped.
    always_comb begin
        tgt      = jump_b_sel ? (pc_add2 + disp) : (rs + imm);
        misalign = tgt[0];
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential increment, EX-resolved redirects, icache
// backpressure via a held redirect target, pipeline flushes, halt and
// misaligned-target stop.
//
// Icache handshake: fetch_req is a level request for the address on pc;
// pc stays stable while a fetch is outstanding. if_ready is a one-cycle
// completion strobe: on any cycle it is high the fetch at pc is done and
// pc may move on the next edge.
`timescale 1ns/1ps
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_ready,
    input  logic            stall_hz,
    input  logic            halt_in,
    input  logic            ex_redirect,
    input  logic            ex_jump_B_sel,
    input  logic [PC_W-1:0] ex_pc_add2,
    input  logic [PC_W-1:0] ex_disp,
    input  logic [PC_W-1:0] ex_rs,
    input  logic [PC_W-1:0] ex_imm,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_add2,
    output logic            fetch_req,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            redirect_busy,
    output logic            halted,
    output logic            misalign_err,
    output logic [1:0]      state_dbg
);

    pc_state_e       state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] tgt_q;
    logic            misalign_q;
    logic [PC_W-1:0] tgt;
    logic            tgt_misalign;

    pc_target_calc #(.PC_W(PC_W)) u_target (
        .jump_b_sel (ex_jump_B_sel),
        .pc_add2    (ex_pc_add2),
        .disp       (ex_disp),
        .rs         (ex_rs),
        .imm        (ex_imm),
        .tgt        (tgt),
        .misalign   (tgt_misalign)
    );

    // PC, pending target, sticky error and control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    // A redirect outranks both halt and hazard stall.
                    if (ex_redirect) begin
                        if (tgt_misalign) begin
                            state      <= ST_ERR;
                            misalign_q <= 1'b1;
                        end else if (if_ready) begin
                            pc_q <= tgt;
                        end else begin
                            // Keep pc so the in-flight access finishes intact.
                            tgt_q <= tgt;
                            state <= ST_HOLD;
                        end
                    end else if (halt_in) begin
                        state <= ST_HALT;
                    end else if (if_ready && !stall_hz) begin
                        pc_q <= pc_q + PC_W'(2);
                    end
                end
                ST_HOLD: begin
                    // Stall and further redirects are not looked at here.
                    if (if_ready) begin
                        pc_q  <= tgt_q;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // Flushes: full flush on an accepted redirect, IF/ID only when the
    // wrong-path word returns at the end of a held redirect.
    always_comb begin
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!rst) begin
            if (state == ST_RUN && ex_redirect && !tgt_misalign) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (state == ST_HOLD && if_ready) begin
                flush_ifid = 1'b1;
            end
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        pc            = pc_q;
        pc_add2       = pc_q + PC_W'(2);
        fetch_req     = !rst && (state == ST_RUN || state == ST_HOLD);
        redirect_busy = (state == ST_HOLD);
        halted        = (state == ST_HALT);
        misalign_err  = misalign_q;
        state_dbg     = state;
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: per-scenario stimulus tables, expected
// outputs pushed to a queue as each cycle is driven and popped when the
// DUT outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_pc_redirect_ctrl;

    localparam int W = 38;

    typedef struct packed {
        logic        rst;
        logic        ifr;
        logic        stall;
        logic        halt;
        logic        redir;
        logic        sel;
        logic [15:0] pa2;
        logic [15:0] disp;
        logic [15:0] rs;
        logic [15:0] imm;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_ready = 1'b0;
    logic        stall_hz = 1'b0;
    logic        halt_in = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        ex_jump_B_sel = 1'b0;
    logic [15:0] ex_pc_add2 = '0;
    logic [15:0] ex_disp = '0;
    logic [15:0] ex_rs = '0;
    logic [15:0] ex_imm = '0;
    logic [15:0] pc;
    logic [15:0] pc_add2;
    logic        fetch_req;
    logic        flush_ifid;
    logic        flush_idex;
    logic        redirect_busy;
    logic        halted;
    logic        misalign_err;
    logic [1:0]  state_dbg;

    logic [W-1:0] obs;
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    pc_redirect_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_ready      (if_ready),
        .stall_hz      (stall_hz),
        .halt_in       (halt_in),
        .ex_redirect   (ex_redirect),
        .ex_jump_B_sel (ex_jump_B_sel),
        .ex_pc_add2    (ex_pc_add2),
        .ex_disp       (ex_disp),
        .ex_rs         (ex_rs),
        .ex_imm        (ex_imm),
        .pc            (pc),
        .pc_add2       (pc_add2),
        .fetch_req     (fetch_req),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .redirect_busy (redirect_busy),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .state_dbg     (state_dbg)
    );

    assign obs = {pc, pc_add2, flush_ifid, flush_idex, fetch_req,
                  redirect_busy, halted, misalign_err};

    // Clock / reset
    always #5 clk = ~clk;

    // ex_redirect while a redirect is held is a protocol violation
    always @(negedge clk) begin
        if (!rst && redirect_busy && ex_redirect)
            $error("protocol: ex_redirect asserted while redirect_busy");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish before 200000");
        $fatal(1, "watchdog");
    end

    // Stimulus builders
    function automatic stim_t st(input logic r, input logic ifr, input logic stall,
                                 input logic halt, input logic redir, input logic sel,
                                 input logic [15:0] pa2, input logic [15:0] disp,
                                 input logic [15:0] rs, input logic [15:0] imm);
        stim_t s;
        s.rst = r; s.ifr = ifr; s.stall = stall; s.halt = halt; s.redir = redir;
        s.sel = sel; s.pa2 = pa2; s.disp = disp; s.rs = rs; s.imm = imm;
        return s;
    endfunction

    function automatic stim_t idle(input logic ifr);
        return st(1'b0, ifr, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    endfunction

    function automatic stim_t rreg(input logic ifr, input logic [15:0] rs, input logic [15:0] imm);
        return st(1'b0, ifr, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, rs, imm);
    endfunction

    function automatic stim_t rst_cyc();
        return st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    endfunction

    // Expected output vector; pc_add2 expectation is pc + 2 mod 2^16
    function automatic logic [W-1:0] ev(input logic [15:0] p, input logic fi, input logic fe,
                                        input logic fr, input logic rb, input logic h,
                                        input logic m);
        return {p, p + 16'd2, fi, fe, fr, rb, h, m};
    endfunction

    // Driver: apply one cycle of inputs just after the rising edge
    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        rst           = s.rst;
        if_ready      = s.ifr;
        stall_hz      = s.stall;
        halt_in       = s.halt;
        ex_redirect   = s.redir;
        ex_jump_B_sel = s.sel;
        ex_pc_add2    = s.pa2;
        ex_disp       = s.disp;
        ex_rs         = s.rs;
        ex_imm        = s.imm;
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [W-1:0] e[$];
        logic [W-1:0] got, want;
        // reset held with a live redirect on the inputs: no flush, no request
        s.push_back(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0040, 16'h0));
        e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0000, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0002, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0004, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h0006, 0, 0, 1, 0, 0, 0));
        // reset raised mid-cycle: pc must clear before the next edge
        s.push_back(rst_cyc());  e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: got pc=%h pc_add2=%h flags=%b, want pc=%h pc_add2=%h flags=%b",
                         i, got[37:22], got[21:6], got[5:0], want[37:22], want[21:6], want[5:0]);
            end
        end
        n_tests++;
        if (state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, want 0", state_dbg);
        end
    endtask

    task automatic test_disp_redirect();
        stim_t s[$];
        logic [W-1:0] e[$];
        logic [W-1:0] got, want;
        s.push_back(rst_cyc()); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            s.push_back(idle(1'b1));
            e.push_back(ev(16'(2 * k), 0, 0, 1, 0, 0, 0));
        end
        // 0x0020 + 0xFFF0 = 0x0010 with the carry dropped
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'hFFF0, 16'h0, 16'h0));
        e.push_back(ev(16'h0010, 1, 1, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h0010, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h0010, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL disp_redirect[%0d]: got pc=%h pc_add2=%h flags=%b, want pc=%h pc_add2=%h flags=%b",
                         i, got[37:22], got[21:6], got[5:0], want[37:22], want[21:6], want[5:0]);
            end
        end
    endtask

    task automatic test_hold_redirect();
        stim_t s[$];
        logic [W-1:0] e[$];
        logic [W-1:0] got, want;
        s.push_back(rst_cyc()); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(rreg(1'b0, 16'h1234, 16'h0004)); e.push_back(ev(16'h0000, 1, 1, 1, 0, 0, 0));
        // stall is ignored while holding
        s.push_back(st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0));
        e.push_back(ev(16'h0000, 0, 0, 1, 1, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h0000, 0, 0, 1, 1, 0, 0));
        s.push_back(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0));
        e.push_back(ev(16'h0000, 1, 0, 1, 1, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h1238, 0, 0, 1, 0, 0, 0));
        // reset while holding discards the pending target
        s.push_back(rreg(1'b0, 16'h2000, 16'h0000)); e.push_back(ev(16'h1238, 1, 1, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h1238, 0, 0, 1, 1, 0, 0));
        s.push_back(rst_cyc());  e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0000, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h0002, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL hold_redirect[%0d]: got pc=%h pc_add2=%h flags=%b, want pc=%h pc_add2=%h flags=%b",
                         i, got[37:22], got[21:6], got[5:0], want[37:22], want[21:6], want[5:0]);
            end
        end
    endtask

    task automatic test_misalign();
        stim_t s[$];
        logic [W-1:0] e[$];
        logic [W-1:0] got, want;
        s.push_back(rst_cyc()); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(rreg(1'b1, 16'h0101, 16'h0000)); e.push_back(ev(16'h0000, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 1));
        s.push_back(rreg(1'b1, 16'h0200, 16'h0000)); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 1));
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0));
        e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 1));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 1));
        s.push_back(rst_cyc());  e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0000, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h0002, 0, 0, 1, 0, 0, 0));
        // odd displacement target also trips the error
        s.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0003, 16'h0, 16'h0));
        e.push_back(ev(16'h0002, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0002, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL misalign[%0d]: got pc=%h pc_add2=%h flags=%b, want pc=%h pc_add2=%h flags=%b",
                         i, got[37:22], got[21:6], got[5:0], want[37:22], want[21:6], want[5:0]);
            end
        end
    endtask

    task automatic test_halt_priority();
        stim_t s[$];
        logic [W-1:0] e[$];
        logic [W-1:0] got, want;
        s.push_back(rst_cyc()); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0040, 16'h0));
        e.push_back(ev(16'h0000, 1, 1, 1, 0, 0, 0));
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0));
        e.push_back(ev(16'h0040, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0040, 0, 0, 0, 0, 1, 0));
        s.push_back(rreg(1'b1, 16'h0080, 16'h0000)); e.push_back(ev(16'h0040, 0, 0, 0, 0, 1, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0040, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL halt_priority[%0d]: got pc=%h pc_add2=%h flags=%b, want pc=%h pc_add2=%h flags=%b",
                         i, got[37:22], got[21:6], got[5:0], want[37:22], want[21:6], want[5:0]);
            end
        end
    endtask

    task automatic test_wrap_stall();
        stim_t s[$];
        logic [W-1:0] e[$];
        logic [W-1:0] got, want;
        s.push_back(rst_cyc()); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(rreg(1'b1, 16'hFFFE, 16'h0000)); e.push_back(ev(16'h0000, 1, 1, 1, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'hFFFE, 0, 0, 1, 0, 0, 0));
        s.push_back(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0));
        e.push_back(ev(16'h0000, 0, 0, 1, 0, 0, 0));
        s.push_back(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0));
        e.push_back(ev(16'h0000, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b1)); e.push_back(ev(16'h0000, 0, 0, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'h0002, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wrap_stall[%0d]: got pc=%h pc_add2=%h flags=%b, want pc=%h pc_add2=%h flags=%b",
                         i, got[37:22], got[21:6], got[5:0], want[37:22], want[21:6], want[5:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        logic [W-1:0] e[$];
        logic [W-1:0] got, want;
        logic [15:0] r1, r2;
        r1 = 16'($urandom_range(16'h0100, 16'h7FFE)) & 16'hFFFE;
        r2 = 16'($urandom_range(16'h8000, 16'hFFFE)) & 16'hFFFE;
        s.push_back(rst_cyc()); e.push_back(ev(16'h0000, 0, 0, 0, 0, 0, 0));
        s.push_back(rreg(1'b1, 16'h0100, 16'h0000)); e.push_back(ev(16'h0000, 1, 1, 1, 0, 0, 0));
        s.push_back(rreg(1'b1, 16'h0200, 16'h0000)); e.push_back(ev(16'h0100, 1, 1, 1, 0, 0, 0));
        s.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0302, 16'hFFFE, 16'h0, 16'h0));
        e.push_back(ev(16'h0200, 1, 1, 1, 0, 0, 0));
        // random even register target split across rs and imm
        s.push_back(rreg(1'b1, r1, r2)); e.push_back(ev(16'h0300, 1, 1, 1, 0, 0, 0));
        s.push_back(idle(1'b0)); e.push_back(ev(16'(r1 + r2), 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got = obs; want = exp_q.pop_front(); n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got pc=%h pc_add2=%h flags=%b, want pc=%h pc_add2=%h flags=%b",
                         i, got[37:22], got[21:6], got[5:0], want[37:22], want[21:6], want[5:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_disp_redirect();
        test_hold_redirect();
        test_misalign();
        test_halt_priority();
        test_wrap_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
